// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - iterative radix-2 RV32M/RV64M multiply/divide unit
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        operation handshake (in_op = funct3, in_rs1, in_rs2, in_tag)
//   flush                    synchronous kill of any in-flight operation
//   out_valid/out_ready      result handshake (out_result, out_tag)
//   busy                     unit is not idle
//
// Optional macro RV_MULDIV_REUSE_EN keeps the last completed operands and both
// results of their op class, so a matching follow-up op completes in one cycle.
module riscv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [XLEN-1:0]   r_b;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special_res;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_rem_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remv;
    logic [XLEN-1:0]   w_fix_res;

    assign in_ready   = (r_state == S_IDLE) && !flush && !rst;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_result = r_result;
    assign out_tag    = r_tag;

    // MULH, MULHSU, DIV, REM take rs1 as signed; MULH, DIV, REM take rs2 as signed.
    assign w_is_div   = in_op[2];
    assign w_a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op[2] && !in_op[0]);
    assign w_b_signed = (in_op == 3'd1) || (in_op[2] && !in_op[0]);
    assign w_a_neg    = w_a_signed && in_rs1[XLEN-1];
    assign w_b_neg    = w_b_signed && in_rs2[XLEN-1];
    assign w_abs_a    = w_a_neg ? -in_rs1 : in_rs1;
    assign w_abs_b    = w_b_neg ? -in_rs2 : in_rs2;

    assign w_div_zero = w_is_div && (in_rs2 == '0);
    assign w_ovf      = w_is_div && !in_op[0]
                        && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = in_op[1] ? in_rs1 : '1;
        else if (w_ovf)
            w_special_res = in_op[1] ? '0 : in_rs1;
    end

    // One iteration of shift-add multiply and restoring divide.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh   = {r_rem, r_acc[XLEN-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};

    // Sign correction: the remainder takes the dividend's sign.
    assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quot = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_remv = r_neg_a ? -r_rem : r_rem;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            3'd0:          w_fix_res = w_prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:    w_fix_res = w_quot;
            default:       w_fix_res = w_remv;
        endcase
    end

`ifdef RV_MULDIV_REUSE_EN
    logic             r_last_valid;
    logic             r_last_div;
    logic [1:0]       r_last_sgn;
    logic [XLEN-1:0]  r_last_rs1;
    logic [XLEN-1:0]  r_last_rs2;
    logic [XLEN-1:0]  r_last_hi;
    logic [XLEN-1:0]  r_last_lo;
    logic [XLEN-1:0]  r_rs1_raw;
    logic [XLEN-1:0]  r_rs2_raw;
    logic [1:0]       r_sgn;

    // Signedness must match too (MULH vs MULHU differ in the high half); MUL's
    // low half is sign-independent, so it matches any stored multiply.
    assign w_hit = r_last_valid && (r_last_div == w_is_div)
                   && (r_last_rs1 == in_rs1) && (r_last_rs2 == in_rs2)
                   && ((r_last_sgn == {w_a_signed, w_b_signed}) || (in_op == 3'd0));

    always_comb begin
        w_hit_res = '0;
        if (w_is_div)
            w_hit_res = in_op[1] ? r_last_lo : r_last_hi;
        else
            w_hit_res = (in_op == 3'd0) ? r_last_lo : r_last_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_valid <= 1'b0;
            r_last_div   <= 1'b0;
            r_last_sgn   <= 2'b00;
            r_last_rs1   <= '0;
            r_last_rs2   <= '0;
            r_last_hi    <= '0;
            r_last_lo    <= '0;
            r_rs1_raw    <= '0;
            r_rs2_raw    <= '0;
            r_sgn        <= 2'b00;
        end else if (flush) begin
            if (r_state == S_CALC || r_state == S_FIX)
                r_last_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rs1_raw <= in_rs1;
                r_rs2_raw <= in_rs2;
                r_sgn     <= {w_a_signed, w_b_signed};
            end
            if (r_state == S_FIX) begin
                r_last_valid <= 1'b1;
                r_last_div   <= r_op[2];
                r_last_sgn   <= r_sgn;
                r_last_rs1   <= r_rs1_raw;
                r_last_rs2   <= r_rs2_raw;
                r_last_hi    <= r_op[2] ? w_quot : w_prod[2*XLEN-1:XLEN];
                r_last_lo    <= r_op[2] ? w_remv : w_prod[XLEN-1:0];
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 3'd0;
            r_tag    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= in_op;
                        r_tag   <= in_tag;
                        r_neg_a <= w_a_neg;
                        r_neg_b <= w_b_neg;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else if (w_hit) begin
                            r_result <= w_hit_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_b     <= w_abs_b;
                            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                            r_rem   <= '0;
                            r_cnt   <= CW'(XLEN - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_op[2]) begin
                        // Borrow out of the trial subtraction means the quotient bit is 0.
                        r_rem           <= w_rem_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_rem_diff[XLEN-1:0];
                        r_acc[XLEN-1:0] <= {r_acc[XLEN-2:0], !w_rem_diff[XLEN]};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                    end
                    if (r_cnt == '0)
                        r_state <= S_FIX;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                default: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb/tb_riscv_muldiv_unit.sv - directed self-checking bench for riscv_muldiv_unit
module tb_riscv_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef RV_MULDIV_REUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 34;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    // Presents one op for one cycle, then counts cycles until out_valid (bounded).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int lat);
        in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_rs1 = 32'hDEAD_BEEF; in_rs2 = 32'h0BAD_F00D; in_tag = 5'h1F;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_result !== 32'h0 || out_tag !== 5'h0) begin
            n_fail++;
            $display("FAIL reset: valid/busy/ready=%b result=%h tag=%h, required 000/0/0",
                     {out_valid, busy, in_ready}, out_result, out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] as  [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h2};
        logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 3), lat);
            n_checks++;
            if (out_result !== exp[i] || out_tag !== 5'(i + 3) || lat !== 34) begin
                n_fail++;
                $display("FAIL mul[%0d]: result=%h tag=%0d lat=%0d, required %h tag=%0d lat=34",
                         i, out_result, out_tag, lat, exp[i], i + 3);
            end
            retire();
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'h64, 32'h64, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h64, 32'h8000_0000, 32'h0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 20), lat);
            n_checks++;
            if (out_result !== exp[i] || out_tag !== 5'(i + 20) || lat !== 1) begin
                n_fail++;
                $display("FAIL div_special[%0d]: result=%h tag=%0d lat=%0d, required %h tag=%0d lat=1",
                         i, out_result, out_tag, lat, exp[i], i + 20);
            end
            retire();
        end
    endtask

    task automatic test_div_signed_hold();
        int lat;
        int bad = 0;
        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, lat);
        n_checks++;
        if (out_result !== 32'h0 || lat !== 34) begin
            n_fail++;
            $display("FAIL divu_no_ovf: result=%h lat=%0d, required 0 lat=34", out_result, lat);
        end
        retire();
        issue(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd9, lat);
        n_checks++;
        if (out_result !== 32'hFFFF_FFFD || out_tag !== 5'd9 || lat !== 34) begin
            n_fail++;
            $display("FAIL div_neg: result=%h tag=%0d lat=%0d, required fffffffd tag=9 lat=34",
                     out_result, out_tag, lat);
        end
        retire();
        issue(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd10, lat);
        n_checks++;
        if (out_result !== 32'hFFFF_FFFF || out_tag !== 5'd10 || lat !== HIT_LAT) begin
            n_fail++;
            $display("FAIL rem_neg: result=%h tag=%0d lat=%0d, required ffffffff tag=10 lat=%0d",
                     out_result, out_tag, lat, HIT_LAT);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (!out_valid || out_result !== 32'hFFFF_FFFF || out_tag !== 5'd10 || in_ready) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
        end
        retire();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int bad = 0;
        in_op = 3'd0; in_rs1 = 32'h3; in_rs2 = 32'h5; in_tag = 5'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_calc_pre: in_ready=%b busy=%b, required 0/1", in_ready, busy);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc_post: busy=%b in_ready=%b out_valid=%b, required 0/1/0",
                     busy, in_ready, out_valid);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL flush_no_result: %0d cycles valid/busy, required 0", bad);
        end
        flush = 1'b1; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_ready: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        in_op = 3'd1; in_rs1 = 32'h1234_5678; in_rs2 = 32'h9ABC_DEF0; in_tag = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_result !== 32'h0 || out_tag !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_mid: valid/busy/ready=%b result=%h tag=%h, required 000/0/0",
                     {out_valid, busy, in_ready}, out_result, out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
    endtask

    task automatic test_reuse();
        int lat;
        issue(3'd5, 32'd100, 32'd7, 5'd14, lat);
        n_checks++;
        if (out_result !== 32'd14 || lat !== 34) begin
            n_fail++;
            $display("FAIL reuse_divu: result=%0d lat=%0d, required 14 lat=34", out_result, lat);
        end
        retire();
        issue(3'd7, 32'd100, 32'd7, 5'd15, lat);
        n_checks++;
        if (out_result !== 32'd2 || out_tag !== 5'd15 || lat !== HIT_LAT) begin
            n_fail++;
            $display("FAIL reuse_remu: result=%0d tag=%0d lat=%0d, required 2 tag=15 lat=%0d",
                     out_result, out_tag, lat, HIT_LAT);
        end
        retire();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mul();
        test_div_special();
        test_div_signed_hold();
        test_flush();
        test_reset_mid();
        test_reuse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
